// File: rtl/ddr_init_monitor_pkg.sv
// Shared definitions for the DDR1 init monitor: command encodings, error codes,
// mode register field positions and the init FSM state type.
package ddr_init_monitor_pkg;

  // Command encodings as {cs_n, ras_n, cas_n, we_n}; cs_n=1 is DESELECT.
  localparam logic [3:0] COM_LMR = 4'b0000;
  localparam logic [3:0] COM_REF = 4'b0001;
  localparam logic [3:0] COM_PRE = 4'b0010;
  localparam logic [3:0] COM_ACT = 4'b0011;
  localparam logic [3:0] COM_WR  = 4'b0100;
  localparam logic [3:0] COM_RD  = 4'b0101;
  localparam logic [3:0] COM_BST = 4'b0110;
  localparam logic [3:0] COM_NOP = 4'b0111;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SEQ      = 3'd1;
  localparam logic [2:0] ERR_TIMING   = 3'd2;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd3;
  localparam logic [2:0] ERR_DLL_DIS  = 3'd4;
  localparam logic [2:0] ERR_PRE_BANK = 3'd5;

  localparam int MR_BL_LSB       = 0;
  localparam int MR_BL_MSB       = 2;
  localparam int MR_BT_BIT       = 3;
  localparam int MR_CL_LSB       = 4;
  localparam int MR_CL_MSB       = 6;
  localparam int MR_DLL_RST_BIT  = 8;
  localparam int EMR_DLL_DIS_BIT = 0;
  localparam int PRE_ALL_BIT     = 10;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_WAIT_EMR,
    ST_WAIT_MR_DLL,
    ST_WAIT_PRE1,
    ST_WAIT_REF0,
    ST_WAIT_REF1,
    ST_WAIT_MR_CLR,
    ST_WAIT_DLL,
    ST_READY,
    ST_ERROR
  } init_state_e;

  typedef struct packed {
    logic desel;
    logic nop;
    logic pre;
    logic refresh;
    logic lmr;
    logic illegal;
  } cmd_t;

  function automatic logic cmd_is_idle(input cmd_t c);
    return c.desel | c.nop;
  endfunction

endpackage

// File: rtl/ddr_init_monitor_cmd_decode.sv
// Combinational DDR1 command decoder: one-hot command class plus the
// all-bank qualifier for PRECHARGE.
module ddr_cmd_decode
  import ddr_init_monitor_pkg::*;
(
  input  logic ddr_cs_n,
  input  logic ddr_ras_n,
  input  logic ddr_cas_n,
  input  logic ddr_we_n,
  input  logic ddr_a10,
  output cmd_t cmd,
  output logic pre_all
);

  always_comb begin
    cmd = '0;
    if (ddr_cs_n) begin
      cmd.desel = 1'b1;
    end else begin
      case ({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n})
        COM_NOP: cmd.nop     = 1'b1;
        COM_PRE: cmd.pre     = 1'b1;
        COM_REF: cmd.refresh = 1'b1;
        COM_LMR: cmd.lmr     = 1'b1;
        default: cmd.illegal = 1'b1;
      endcase
    end
    pre_all = cmd.pre & ddr_a10;
  end

endmodule

// File: rtl/ddr_init_monitor.sv
// DDR1 power-up init responder/checker: tracks the JEDEC init order and command
// spacing, captures MR/EMR, and flags the first protocol violation.
module ddr_init_monitor
  import ddr_init_monitor_pkg::*;
#(
  parameter int BA_BITS     = 2,
  parameter int ROW_BITS    = 13,
  parameter int T_PWRUP_CYC = 200,
  parameter int T_RP_CYC    = 3,
  parameter int T_MRD_CYC   = 2,
  parameter int T_RFC_CYC   = 10,
  parameter int T_DLL_CYC   = 200
) (
  input  logic                core_clk,
  input  logic                core_rstn_sync,
  input  logic                ddr_cs_n,
  input  logic                ddr_ras_n,
  input  logic                ddr_cas_n,
  input  logic                ddr_we_n,
  input  logic [BA_BITS-1:0]  ddr_ba,
  input  logic [ROW_BITS-1:0] ddr_a,
  output logic                dev_ready,
  output logic [ROW_BITS-1:0] mr_value,
  output logic [ROW_BITS-1:0] emr_value,
  output logic                err_flag,
  output logic [2:0]          err_code
);

  localparam logic [7:0] T_PWRUP_L = 8'(T_PWRUP_CYC);
  localparam logic [7:0] T_RP_L    = 8'(T_RP_CYC);
  localparam logic [7:0] T_MRD_L   = 8'(T_MRD_CYC);
  localparam logic [7:0] T_RFC_L   = 8'(T_RFC_CYC);
  localparam logic [7:0] T_DLL_L   = 8'(T_DLL_CYC);

  cmd_t        cmd;
  logic        pre_all;
  logic        idle;
  logic        is_mr;
  logic        is_emr;
  logic        in_init;
  logic        expected;
  logic        timing_bad;
  logic        dll_clr;
  logic        lmr_write;
  logic [2:0]  err_d;
  init_state_e state_q;
  init_state_e state_d;
  init_state_e adv_state;

  logic [7:0]          gap_q;
  logic [7:0]          pwrup_q;
  logic [7:0]          dll_q;
  logic [7:0]          t_prev_q;
  logic                dev_ready_q;
  logic [ROW_BITS-1:0] mr_q;
  logic [ROW_BITS-1:0] emr_q;
  logic                err_flag_q;
  logic [2:0]          err_code_q;

  ddr_cmd_decode u_cmd_decode (
    .ddr_cs_n  (ddr_cs_n),
    .ddr_ras_n (ddr_ras_n),
    .ddr_cas_n (ddr_cas_n),
    .ddr_we_n  (ddr_we_n),
    .ddr_a10   (ddr_a[PRE_ALL_BIT]),
    .cmd       (cmd),
    .pre_all   (pre_all)
  );

  assign idle    = cmd_is_idle(cmd);
  assign is_mr   = (ddr_ba == BA_BITS'(0));
  assign is_emr  = (ddr_ba == BA_BITS'(1));
  assign in_init = (state_q != ST_READY) && (state_q != ST_ERROR);

  always_comb begin
    expected   = 1'b0;
    adv_state  = state_q;
    err_d      = ERR_NONE;
    state_d    = state_q;
    // gap_q holds (cycles since last command - 1) when the next command is sampled
    timing_bad = (state_q == ST_PWRUP) ? (pwrup_q < T_PWRUP_L)
                                       : (({1'b0, gap_q} + 9'd1) < {1'b0, t_prev_q});

    case (state_q)
      ST_PWRUP:       begin expected = pre_all;                                  adv_state = ST_WAIT_EMR;    end
      ST_WAIT_EMR:    begin expected = cmd.lmr & is_emr;                         adv_state = ST_WAIT_MR_DLL; end
      ST_WAIT_MR_DLL: begin expected = cmd.lmr & is_mr & ddr_a[MR_DLL_RST_BIT];  adv_state = ST_WAIT_PRE1;   end
      ST_WAIT_PRE1:   begin expected = pre_all;                                  adv_state = ST_WAIT_REF0;   end
      ST_WAIT_REF0:   begin expected = cmd.refresh;                              adv_state = ST_WAIT_REF1;   end
      ST_WAIT_REF1:   begin expected = cmd.refresh;                              adv_state = ST_WAIT_MR_CLR; end
      ST_WAIT_MR_CLR: begin expected = cmd.lmr & is_mr & ~ddr_a[MR_DLL_RST_BIT]; adv_state = ST_WAIT_DLL;    end
      default:        begin expected = 1'b0;                                     adv_state = state_q;        end
    endcase

    if (in_init && !idle) begin
      if (cmd.illegal)                                     err_d = ERR_ILLEGAL;
      else if (timing_bad)                                 err_d = ERR_TIMING;
      else if (cmd.pre && !pre_all)                        err_d = ERR_PRE_BANK;
      else if (cmd.lmr && is_emr && ddr_a[EMR_DLL_DIS_BIT]) err_d = ERR_DLL_DIS;
      else if (!expected)                                  err_d = ERR_SEQ;
    end

    if (err_d != ERR_NONE)                             state_d = ST_ERROR;
    else if (in_init && !idle)                         state_d = adv_state;
    else if (state_q == ST_WAIT_DLL && dll_q >= T_DLL_L) state_d = ST_READY;

    dll_clr   = (state_q == ST_WAIT_MR_DLL) && !idle && (err_d == ERR_NONE);
    lmr_write = cmd.lmr && ((in_init && err_d == ERR_NONE) || state_q == ST_READY);
  end

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state_q <= ST_PWRUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      gap_q       <= '0;
      pwrup_q     <= '0;
      dll_q       <= '0;
      t_prev_q    <= '0;
      dev_ready_q <= 1'b0;
      mr_q        <= '0;
      emr_q       <= '0;
      err_flag_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if (!idle)                gap_q <= '0;
      else if (gap_q != 8'hff)  gap_q <= gap_q + 8'd1;

      if (idle && pwrup_q != 8'hff) pwrup_q <= pwrup_q + 8'd1;

      if (dll_clr)              dll_q <= '0;
      else if (dll_q != 8'hff)  dll_q <= dll_q + 8'd1;

      if (!idle) begin
        if (cmd.pre)          t_prev_q <= T_RP_L;
        else if (cmd.lmr)     t_prev_q <= T_MRD_L;
        else if (cmd.refresh) t_prev_q <= T_RFC_L;
        else                  t_prev_q <= '0;
      end

      if (state_q == ST_READY) dev_ready_q <= 1'b1;

      if (!err_flag_q && err_d != ERR_NONE) begin
        err_flag_q <= 1'b1;
        err_code_q <= err_d;
      end

      if (lmr_write && is_mr)  mr_q  <= ddr_a;
      if (lmr_write && is_emr) emr_q <= ddr_a;
    end
  end

  assign dev_ready = dev_ready_q;
  assign mr_value  = mr_q;
  assign emr_value = emr_q;
  assign err_flag  = err_flag_q;
  assign err_code  = err_code_q;

endmodule
